timer_display: RTL

TIMER_DISPLAY -- requirements
Module: timer_display

---
 rtl/timer_display_pkg.sv | 42 ++++
 rtl/timer_display_bin2bcd_2digit.sv | 11 +
 rtl/timer_display.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/timer_display_pkg.sv
// Shared types and constants for the four-digit MM:SS seven-segment display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package timer_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_t;

    function automatic seg_t seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/timer_display_bin2bcd_2digit.sv
// Combinational split of a 0..63 binary value into tens and ones BCD digits.
module bin2bcd_2digit (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    assign tens = 4'(bin / 6'd10);
    assign ones = 4'(bin % 6'd10);

endmodule

// File: rtl/timer_display.sv
// Multiplexed MM:SS seven-segment driver: clamp/BCD pipeline, scan prescaler,
// digit rotation, expiry blinking and registered active-low outputs.
module timer_display
    import timer_display_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       blink,
    output logic [3:0] an,
    output seg_t       seg,
    output logic       dp
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    function automatic logic [5:0] clamp59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    logic [5:0] min_p0, sec_p0;
    logic [3:0] min_tens_p1, min_ones_p1, sec_tens_p1, sec_ones_p1;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic          lit;
    digit_t        dig, dig_next;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    logic [3:0]    an_d;
    seg_t          seg_d;
    logic          dp_d;

    // stage p0: clamp the raw timer values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_p0 <= '0;
            sec_p0 <= '0;
        end else begin
            min_p0 <= clamp59(minutes);
            sec_p0 <= clamp59(seconds);
        end
    end

    bin2bcd_2digit u_min_bcd (.bin(min_p0), .tens(min_tens), .ones(min_ones));
    bin2bcd_2digit u_sec_bcd (.bin(sec_p0), .tens(sec_tens), .ones(sec_ones));

    // stage p1: BCD digits ready for selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_tens_p1 <= '0;
            min_ones_p1 <= '0;
            sec_tens_p1 <= '0;
            sec_ones_p1 <= '0;
        end else begin
            min_tens_p1 <= min_tens;
            min_ones_p1 <= min_ones;
            sec_tens_p1 <= sec_tens;
            sec_ones_p1 <= sec_ones;
        end
    end

    assign tick = (pre_cnt == PW'(DIV - 1));

    always_comb begin
        dig_next = dig;
        case (dig)
            DIG_SEC_ONES: dig_next = DIG_SEC_TENS;
            DIG_SEC_TENS: dig_next = DIG_MIN_ONES;
            DIG_MIN_ONES: dig_next = DIG_MIN_TENS;
            DIG_MIN_TENS: dig_next = DIG_SEC_ONES;
            default:      dig_next = DIG_SEC_ONES;
        endcase
    end

    // The first tick after reset only arms the display, so digit 0 lights first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            lit     <= 1'b0;
            dig     <= DIG_SEC_ONES;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) begin
                if (!lit) lit <= 1'b1;
                else      dig <= dig_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!blink) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // blink gates the phase directly so dropping it shows digits on the next clk
    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (en && lit && !(blink && phase)) begin
            case (dig)
                DIG_SEC_ONES: begin
                    an_d  = 4'b1110;
                    seg_d = seg_of(sec_ones_p1);
                end
                DIG_SEC_TENS: begin
                    an_d  = 4'b1101;
                    seg_d = seg_of(sec_tens_p1);
                end
                DIG_MIN_ONES: begin
                    an_d  = 4'b1011;
                    seg_d = seg_of(min_ones_p1);
                    dp_d  = 1'b0;
                end
                DIG_MIN_TENS: begin
                    if (min_tens_p1 != 4'd0) begin
                        an_d  = 4'b0111;
                        seg_d = seg_of(min_tens_p1);
                    end
                end
                default: ;
            endcase
        end
    end

    // output stage: registered drive of anodes, segments and decimal point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
